seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector, next generation of the fixed 2-bit-state FSM detectors.

---
 rtl/seq_det_pkg.sv | 38 +++
 rtl/seq_detector_param_sat_counter.sv | 38 +++
 rtl/seq_detector_param.sv | 147 ++++++++++++++
 tb/tb_seq_detector_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Purpose : Shared types and helpers for the parametrised serial
//           pattern detector (seq_detector_param) and its match counter.
// Contents: state_t     - detector FSM states (IDLE, RUN)
//           calc_len_w  - width needed to hold a length 0..max
//           clamp_len   - folds a requested pattern length into 1..max
// ---------------------------------------------------------------------------
package seq_det_pkg;

  // Default maximum pattern length and the matching length-port width.
  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_LEN_W   = $clog2(DEFAULT_MAX_LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bits needed to represent any value 0..max inclusive.
  function automatic int calc_len_w(input int max);
    return $clog2(max + 1);
  endfunction

  // A zero-length pattern would match every sample vacuously and a length
  // beyond the history register cannot be compared, so both are folded
  // into the legal 1..max range when the configuration is latched.
  function automatic int clamp_len(input int len, input int max);
    if (len < 1) begin
      return 1;
    end else if (len > max) begin
      return max;
    end else begin
      return len;
    end
  endfunction

endpackage : seq_det_pkg

// File: rtl/seq_detector_param_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Purpose : W-bit up counter that sticks at all-ones instead of wrapping.
//           Used as the match counter of seq_detector_param.
// Ports   : clk   in  1  rising-edge clock
//           rst_n in  1  async active-low reset, clears the count
//           inc   in  1  add one this cycle (ignored once saturated)
//           clr   in  1  synchronous clear, has priority over inc
//           q     out W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = &r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && !w_at_max) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
// Purpose : Runtime-configurable serial bit-pattern detector for one lane.
//           A pattern of 1..MAX_LEN bits is compared against the most
//           recent valid samples; a hit produces a registered one-cycle
//           match pulse and bumps a saturating match counter.
// Ports   : clk          in  1        rising-edge clock
//           rst_n        in  1        async active-low reset
//           cfg_load     in  1        latch cfg_* this cycle (re-arms)
//           cfg_pattern  in  MAX_LEN  pattern, bit[len-1] received first
//           cfg_len      in  LEN_W    pattern length (clamped to 1..MAX_LEN)
//           cfg_overlap  in  1        1: overlapping matches, 0: restart
//           en           in  1        x is a valid sample this cycle
//           x            in  1        serial input bit
//           armed        out 1        configured and running
//           match        out 1        one-cycle match pulse
//           match_cnt    out CNT_W    saturating matches since cfg/reset
// ---------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               en,
  input  logic               x,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  // Configuration registers
  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;

  // Datapath registers
  logic [MAX_LEN-1:0] r_hist;   // newest sample in bit 0
  logic [LEN_W-1:0]   r_vcnt;   // samples usable for the next compare
  logic               r_armed;
  logic               r_match;

  // Combinational helpers
  logic [LEN_W-1:0]   w_len_clamped;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_vcnt_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_pattern_eq;
  logic               w_sample;
  logic               w_hit;

  assign w_len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));

  // History as it will look after this sample is shifted in.
  assign w_hist_next = {r_hist[MAX_LEN-2:0], x};

  // Valid count saturates at MAX_LEN: older bits fall off the shift register.
  assign w_vcnt_inc = (r_vcnt == LEN_MAX) ? r_vcnt : (r_vcnt + LEN_W'(1));

  // Per-bit enable of the comparison: only the low r_len history bits
  // take part, so pattern bits above the length are don't-care.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign w_mask[gi] = (LEN_W'(gi) < r_len);
  end

  assign w_pattern_eq = ~|((w_hist_next ^ r_pattern) & w_mask);

  // A valid sample is consumed only in RUN and only when no reconfiguration
  // happens on the same edge (the load discards that sample).
  assign w_sample = (r_state == RUN) && en && !cfg_load;

  assign w_hit = w_sample && (w_vcnt_inc >= r_len) && w_pattern_eq;

  // Control FSM, configuration latch, history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_hist    <= '0;
      r_vcnt    <= '0;
      r_armed   <= 1'b0;
      r_match   <= 1'b0;
    end else if (cfg_load) begin
      // Loading from either state (re)arms with a clean history.
      r_state   <= RUN;
      r_pattern <= cfg_pattern;
      r_len     <= w_len_clamped;
      r_overlap <= cfg_overlap;
      r_hist    <= '0;
      r_vcnt    <= '0;
      r_armed   <= 1'b1;
      r_match   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_armed <= 1'b0;
          r_match <= 1'b0;
        end
        RUN: begin
          r_armed <= 1'b1;
          r_match <= w_hit;
          if (w_sample) begin
            r_hist <= w_hist_next;
            // Non-overlapping mode: bits that formed this match may not
            // be reused, so the next match needs a full fresh pattern.
            if (w_hit && !r_overlap) begin
              r_vcnt <= '0;
            end else begin
              r_vcnt <= w_vcnt_inc;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_armed <= 1'b0;
          r_match <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit),
    .clr   (cfg_load),
    .q     (match_cnt)
  );

  assign armed = r_armed;
  assign match = r_match;

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
// Purpose : Self-checking bench for seq_detector_param (MAX_LEN=8, CNT_W=2).
//           Each transaction drives one clock of stimulus, a behavioural
//           model pushes the expected outputs to a scoreboard queue, and
//           the entry is popped and compared once the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               en;
  logic               x;
  logic               armed;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;

  always #5 clk = ~clk;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .en          (en),
    .x           (x),
    .armed       (armed),
    .match       (match),
    .match_cnt   (match_cnt)
  );

  typedef struct {
    string            tag;
    logic             match;
    logic             armed;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: history kept as the list of samples seen since the
  // last restart (newest at the back), capped at MAX_LEN entries.
  bit               m_armed = 1'b0;
  logic [MAX_LEN-1:0] m_pat = '0;
  int               m_len = 0;
  bit               m_ov  = 1'b0;
  bit               m_bits[$];
  int               m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0;
    m_pat   = '0;
    m_len   = 0;
    m_ov    = 1'b0;
    m_bits.delete();
    m_cnt   = 0;
  endtask

  // One transaction: drive on the falling edge, predict, clock, compare.
  task automatic step(input string tag, input bit load, input logic [MAX_LEN-1:0] pat,
                      input logic [LEN_W-1:0] len, input bit ov, input bit e, input bit xb);
    exp_t t;
    exp_t got;
    bit   hit;
    cfg_load    = load;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    en          = e;
    x           = xb;

    t.tag   = tag;
    t.match = 1'b0;
    if (load) begin
      m_armed = 1'b1;
      m_pat   = pat;
      m_len   = (int'(len) == 0) ? 1 : ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len));
      m_ov    = ov;
      m_bits.delete();
      m_cnt   = 0;
    end else if (m_armed && e) begin
      m_bits.push_back(xb);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      hit = (m_bits.size() >= m_len);
      for (int k = 0; k < m_len && hit; k++) begin
        if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit) begin
        t.match = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ov) m_bits.delete();
      end
    end
    t.armed = m_armed;
    t.cnt   = CNT_W'(m_cnt);
    sb.push_back(t);

    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    en       = 1'b0;
    @(negedge clk);

    got = sb.pop_front();
    $display("txn %-8s load=%0b en=%0b x=%0b -> match=%0b armed=%0b cnt=%0d",
             got.tag, load, e, xb, match, armed, match_cnt);
    chk({got.tag, ".match"}, 32'(match), 32'(got.match));
    chk({got.tag, ".armed"}, 32'(armed), 32'(got.armed));
    chk({got.tag, ".cnt"},   32'(match_cnt), 32'(got.cnt));
  endtask

  task automatic load_cfg(input string tag, input logic [MAX_LEN-1:0] pat,
                          input logic [LEN_W-1:0] len, input bit ov);
    step(tag, 1'b1, pat, len, ov, 1'b0, 1'b0);
  endtask

  task automatic feed(input string tag, input bit xb);
    step(tag, 1'b0, '0, '0, 1'b0, 1'b1, xb);
  endtask

  task automatic gap(input string tag);
    step(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".match"}, 32'(match), 32'd0);
    chk({tag, ".armed"}, 32'(armed), 32'd0);
    chk({tag, ".cnt"},   32'(match_cnt), 32'd0);
  endtask

  initial begin
    logic [MAX_LEN-1:0] p;
    logic [4:0]         s_101;
    rst_n       = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    en          = 1'b0;
    x           = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Unconfigured: samples are ignored.
    for (int i = 0; i < 20; i++) feed("idle", 1'b1);

    // 101 overlapping on 1,0,1,0,1; the load also carries en=1 to show the
    // sample on a load edge is discarded.
    s_101 = 5'b10101;
    step("ov1", 1'b1, 8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
    for (int i = 4; i >= 0; i--) feed("ov1", s_101[i]);

    // Same stream, non-overlapping.
    load_cfg("ov0", 8'b101, 4'd3, 1'b0);
    for (int i = 4; i >= 0; i--) feed("ov0", s_101[i]);

    // Idle cycles between samples have no effect.
    load_cfg("gaps", 8'b101, 4'd3, 1'b1);
    feed("gaps", 1'b1);
    gap("gaps");
    feed("gaps", 1'b0);
    gap("gaps");
    feed("gaps", 1'b1);

    // Length-1 pattern: match every sample, counter saturates at 3.
    load_cfg("sat", 8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) feed("sat", 1'b1);

    // Reload mid-stream: old history must not contribute.
    load_cfg("reld", 8'b101, 4'd3, 1'b1);
    feed("reld", 1'b1);
    feed("reld", 1'b0);
    load_cfg("reld0", 8'b0, 4'd0, 1'b0);
    feed("reld0", 1'b0);
    load_cfg("reld2", 8'b100, 4'd2, 1'b1);
    feed("reld2", 1'b0);
    feed("reld2", 1'b0);

    // Pattern bits above length are don't-care.
    load_cfg("dc", 8'hF2, 4'd2, 1'b1);
    feed("dc", 1'b1);
    feed("dc", 1'b0);

    // Oversized length clamps to MAX_LEN: full 8-bit compare.
    p = 8'hA5;
    load_cfg("clamp", p, 4'd15, 1'b1);
    for (int i = MAX_LEN - 1; i >= 0; i--) feed("clamp", p[i]);
    feed("clamp", 1'b1);

    // Asynchronous reset while match is high.
    load_cfg("arst", 8'b11, 4'd2, 1'b1);
    feed("arst", 1'b1);
    feed("arst", 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_cleared("arst_now");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) feed("post", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_detector_param
